ldmx_link_tx: RTL

LDMX_LINK_TX -- requirements
Module: ldmx_link_tx

---
 rtl/ldmx_link_tx.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ldmx_link_tx.sv
// LDMX event link transmitter: frames payload words as SOP / payload / TRAILER / EOP
// followed by a minimum idle gap, with per-event length and checksum.
module ldmx_link_tx #(
  parameter int MIN_GAP = 2,
  parameter int MAX_LEN = 2047
) (
  input  logic        clk_link,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  fpga_id,
  input  logic [31:0] evt_data,
  input  logic        evt_valid,
  input  logic        evt_last,
  output logic        evt_ready,
  output logic [31:0] link_data,
  output logic [3:0]  link_is_k,
  output logic        link_valid,
  output logic        tx_busy,
  output logic [31:0] events_sent
);

  localparam logic [31:0] IDLE_WORD = 32'h505050BC;
  localparam logic [31:0] EOP_WORD  = 32'h000000DC;
  localparam logic [3:0]  K_CTRL    = 4'b0001;
  localparam logic [10:0] MAX_LEN_W = 11'(MAX_LEN);
  localparam logic [3:0]  GAP_LOAD  = 4'(MIN_GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOP,
    ST_PAYLOAD,
    ST_TRAILER,
    ST_EOP,
    ST_GAP
  } state_t;

  state_t      state, state_next;
  logic [10:0] len;
  logic [15:0] csum;
  logic        trunc;
  logic [3:0]  gap_cnt;
  logic [31:0] data_next;
  logic [3:0]  k_next;
  logic        valid_next;
  logic        xfer;
  logic        keep;

  assign evt_ready = (state == ST_PAYLOAD);
  assign tx_busy   = (state != ST_IDLE);
  assign xfer      = evt_ready && evt_valid;
  // Words past MAX_LEN are still consumed, but only counted ones reach the link.
  assign keep      = xfer && (len < MAX_LEN_W);

  always_ff @(posedge clk_link) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    data_next  = IDLE_WORD;
    k_next     = K_CTRL;
    valid_next = 1'b1;
    case (state)
      ST_IDLE: begin
        valid_next = enable;
        if (enable && evt_valid) state_next = ST_SOP;
      end
      ST_SOP: begin
        data_next  = {fpga_id, events_sent[7:0], 8'h00, 8'h3C};
        state_next = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (keep) begin
          data_next = evt_data;
          k_next    = 4'b0000;
        end
        if (xfer && evt_last) state_next = ST_TRAILER;
      end
      ST_TRAILER: begin
        data_next  = {trunc, 4'h0, len, csum};
        k_next     = 4'b0000;
        state_next = ST_EOP;
      end
      ST_EOP: begin
        data_next  = EOP_WORD;
        state_next = ST_GAP;
      end
      ST_GAP: begin
        // Leaving straight for SOP keeps the idle run at exactly MIN_GAP words.
        if (gap_cnt == 4'd0) state_next = (enable && evt_valid) ? ST_SOP : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_link) begin
    if (reset) begin
      link_data   <= 32'h0;
      link_is_k   <= 4'h0;
      link_valid  <= 1'b0;
      events_sent <= 32'h0;
      len         <= 11'd0;
      csum        <= 16'h0;
      trunc       <= 1'b0;
      gap_cnt     <= 4'd0;
    end else begin
      link_data  <= data_next;
      link_is_k  <= k_next;
      link_valid <= valid_next;
      case (state)
        ST_SOP: begin
          len   <= 11'd0;
          csum  <= 16'h0;
          trunc <= 1'b0;
        end
        ST_PAYLOAD: begin
          if (keep) begin
            len  <= len + 11'd1;
            csum <= csum + evt_data[31:16] + evt_data[15:0];
          end else if (xfer) begin
            trunc <= 1'b1;
          end
        end
        ST_EOP: begin
          events_sent <= events_sent + 32'd1;
          gap_cnt     <= GAP_LOAD;
        end
        ST_GAP: begin
          if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
